// File: rtl/fib_stream_checker.sv
// Fibonacci stream self-check monitor: accepts WIDTH-bit terms over valid/ready and verifies the 0,1 seeded recurrence.
// Optional build macro FIB_CHK_WRAP_EN: sums wrap mod 2^WIDTH instead of ending in S_DONE on overflow.
module fib_stream_checker #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] exp_data,
    output logic [CNT_W-1:0] term_cnt,
    output logic             seq_ok,
    output logic             err,
    output logic [CNT_W-1:0] err_idx,
    output logic             done
);
    typedef enum logic [2:0] {S_SEED0, S_SEED1, S_RUN, S_ERR, S_DONE} state_t;

`ifdef FIB_CHK_WRAP_EN
    localparam int SUM_W = WIDTH;
`else
    localparam int SUM_W = WIDTH + 1;
`endif

    state_t           state_q;
    logic [WIDTH-1:0] prev_a_q, prev_b_q, exp_q;
    logic [CNT_W-1:0] cnt_q, err_idx_q;
    logic             err_q, done_q;

    logic [SUM_W-1:0] sum;
    logic [WIDTH-1:0] exp_cmp;
    logic [CNT_W-1:0] cnt_inc;
    logic             match;

    // In S_RUN the expected term is rebuilt from the two previous terms; exp_q carries the same value.
    assign exp_cmp  = (state_q == S_RUN) ? WIDTH'(prev_a_q + prev_b_q) : exp_q;
    assign match    = (in_data == exp_cmp);
    assign sum      = SUM_W'(prev_b_q) + SUM_W'(in_data);
    assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    assign in_ready = rst_n && !clear &&
                      (state_q == S_SEED0 || state_q == S_SEED1 || state_q == S_RUN);
    assign exp_data = exp_q;
    assign term_cnt = cnt_q;
    assign err      = err_q;
    assign err_idx  = err_idx_q;
    assign seq_ok   = (cnt_q >= CNT_W'(2)) && !err_q;
    assign done     = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_SEED0;
            prev_a_q  <= '0;
            prev_b_q  <= '0;
            exp_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            done_q    <= 1'b0;
        end else if (clear) begin
            state_q   <= S_SEED0;
            prev_a_q  <= '0;
            prev_b_q  <= '0;
            exp_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            done_q    <= 1'b0;
        end else if (in_valid && in_ready) begin
            if (!match) begin
                state_q   <= S_ERR;
                err_q     <= 1'b1;
                err_idx_q <= cnt_q;
            end else begin
                cnt_q <= cnt_inc;
                case (state_q)
                    S_SEED0: begin
                        state_q  <= S_SEED1;
                        prev_b_q <= '0;
                        exp_q    <= WIDTH'(1);
                    end
                    S_SEED1: begin
                        state_q  <= S_RUN;
                        prev_a_q <= '0;
                        prev_b_q <= WIDTH'(1);
                        exp_q    <= WIDTH'(1);
                    end
                    default: begin
                        prev_a_q <= prev_b_q;
                        prev_b_q <= in_data;
                        exp_q    <= sum[WIDTH-1:0];
`ifndef FIB_CHK_WRAP_EN
                        // Next term no longer fits: the stream is complete, not wrong.
                        if (sum[WIDTH]) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
`endif
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fib_stream_checker.sv
// Table-driven directed bench for fib_stream_checker (WIDTH=8, CNT_W=8).
module tb_fib_stream_checker;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, seq_ok, err, done;
    logic [7:0] exp_data, term_cnt, err_idx;

    int n_cmp = 0;
    int n_bad = 0;

    fib_stream_checker #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .exp_data(exp_data), .term_cnt(term_cnt), .seq_ok(seq_ok),
        .err(err), .err_idx(err_idx), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vld, clr;
        logic [7:0] dat;
        logic       rdy;
        logic [7:0] exp, cnt;
        logic       er;
        logic [7:0] idx;
        logic       seq, dn;
    } vec_t;

    function automatic vec_t mk(logic vld, logic [7:0] dat, logic clr, logic rdy, logic [7:0] exp,
                                logic [7:0] cnt, logic er, logic [7:0] idx, logic seq, logic dn);
        vec_t v;
        v.vld = vld; v.dat = dat; v.clr = clr; v.rdy = rdy; v.exp = exp;
        v.cnt = cnt; v.er = er; v.idx = idx; v.seq = seq; v.dn = dn;
        return v;
    endfunction

    task automatic chk(string name, int i, logic [31:0] act, logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0d want %0d", name, i, act, want);
        end
    endtask

    task automatic chk_out(string tag, int i, vec_t v);
        chk({tag, ".exp_data"}, i, 32'(exp_data), 32'(v.exp));
        chk({tag, ".term_cnt"}, i, 32'(term_cnt), 32'(v.cnt));
        chk({tag, ".err"},      i, 32'(err),      32'(v.er));
        chk({tag, ".err_idx"},  i, 32'(err_idx),  32'(v.idx));
        chk({tag, ".seq_ok"},   i, 32'(seq_ok),   32'(v.seq));
        chk({tag, ".done"},     i, 32'(done),     32'(v.dn));
    endtask

    // Drive at negedge, check in_ready before the edge, check registered outputs #1 after it.
    task automatic run_vec(string tag, int i, vec_t v);
        @(negedge clk);
        in_valid = v.vld; in_data = v.dat; clear = v.clr;
        #1 chk({tag, ".in_ready"}, i, 32'(in_ready), 32'(v.rdy));
        @(posedge clk);
        #1 chk_out(tag, i, v);
    endtask

    task automatic do_reset(string tag);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h00; clear = 1'b0;
        #1 chk({tag, ".rst_ready"}, 0, 32'(in_ready), 32'd0);
        chk_out({tag, ".rst"}, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    vec_t q[$];
    logic [7:0] fib [14] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                             8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233};
    logic [7:0] nxt [14] = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21,
                             8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121};

    initial begin
        // Full 8-bit stream, in_valid held high, one transfer per cycle.
        do_reset("fib");
        q = {};
`ifdef FIB_CHK_WRAP_EN
        for (int i = 0; i < 14; i++)
            q.push_back(mk(1, fib[i], 0, 1, nxt[i], 8'(i + 1), 0, 0, (i >= 1), 0));
        q.push_back(mk(1, 8'd121, 0, 1, 8'd98, 8'd15, 0, 0, 1, 0));
`else
        for (int i = 0; i < 14; i++)
            q.push_back(mk(1, fib[i], 0, 1, nxt[i], 8'(i + 1), 0, 0, (i >= 1), (i == 13)));
        q.push_back(mk(1, 8'd121, 0, 0, 8'd121, 8'd14, 0, 0, 1, 1));
`endif
        foreach (q[i]) run_vec("fib", i, q[i]);

        // Bad fifth term, frozen error state, then clear with a simultaneous valid term.
        do_reset("bad");
        q = {};
        q.push_back(mk(1, 8'd0, 0, 1, 8'd1, 8'd1, 0, 0, 0, 0));
        q.push_back(mk(1, 8'd1, 0, 1, 8'd1, 8'd2, 0, 0, 1, 0));
        q.push_back(mk(1, 8'd1, 0, 1, 8'd2, 8'd3, 0, 0, 1, 0));
        q.push_back(mk(1, 8'd2, 0, 1, 8'd3, 8'd4, 0, 0, 1, 0));
        q.push_back(mk(1, 8'd4, 0, 1, 8'd3, 8'd4, 1, 8'd4, 0, 0));
        q.push_back(mk(1, 8'd3, 0, 0, 8'd3, 8'd4, 1, 8'd4, 0, 0));
        q.push_back(mk(1, 8'd0, 1, 0, 8'd0, 8'd0, 0, 0, 0, 0));
        q.push_back(mk(1, 8'd0, 0, 1, 8'd1, 8'd1, 0, 0, 0, 0));
        q.push_back(mk(1, 8'd1, 0, 1, 8'd1, 8'd2, 0, 0, 1, 0));
        foreach (q[i]) run_vec("bad", i, q[i]);

        // Wrong seed term.
        do_reset("seed");
        run_vec("seed", 0, mk(1, 8'd5, 0, 1, 8'd0, 8'd0, 1, 8'd0, 0, 0));

        // Gapped valid with garbage data on idle cycles.
        do_reset("gap");
        q = {};
        q.push_back(mk(1, 8'h00, 0, 1, 8'd1, 8'd1, 0, 0, 0, 0));
        q.push_back(mk(0, 8'hFF, 0, 1, 8'd1, 8'd1, 0, 0, 0, 0));
        q.push_back(mk(1, 8'h01, 0, 1, 8'd1, 8'd2, 0, 0, 1, 0));
        q.push_back(mk(0, 8'hFF, 0, 1, 8'd1, 8'd2, 0, 0, 1, 0));
        q.push_back(mk(1, 8'h01, 0, 1, 8'd2, 8'd3, 0, 0, 1, 0));
        q.push_back(mk(0, 8'hFF, 0, 1, 8'd2, 8'd3, 0, 0, 1, 0));
        foreach (q[i]) run_vec("gap", i, q[i]);

        // Asynchronous reset between edges after six terms.
        do_reset("arst");
        for (int i = 0; i < 6; i++)
            run_vec("arst", i, mk(1, fib[i], 0, 1, nxt[i], 8'(i + 1), 0, 0, (i >= 1), 0));
        #2 rst_n = 1'b0;
        #1 chk("arst.mid_ready", 0, 32'(in_ready), 32'd0);
        chk_out("arst.mid", 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'd0;
        #1 chk("arst.hold_ready", 0, 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 chk_out("arst.hold", 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("arst.rel_ready", 0, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 chk_out("arst.rel", 0, mk(1, 0, 0, 1, 8'd1, 8'd1, 0, 0, 0, 0));

        in_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fib_stream_checker.md
Name: fib_stream_checker

Overview:
- Receiving end of the team's Fibonacci term stream: consumes WIDTH-bit terms over a valid/ready handshake.
- Verifies each term against the sequence seeded 0, 1: term[n] = term[n-1] + term[n-2].
- Reports term count, first-mismatch index and the expected value.
- Sits downstream of the Fibonacci generator as a self-check monitor, synthesizable for on-chip BIST.

Parameters:
- WIDTH, 8, bit width of each term and of the expected-value datapath.
- CNT_W, 8, bit width of term_cnt and err_idx.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous restart to the seed-0 state; priority over everything except rst_n.
- in_valid  in  1  upstream term present.
- in_data  in  WIDTH  term value.
- in_ready  out  1  checker accepts a term this cycle.
- exp_data  out  WIDTH  value the next accepted term must equal.
- term_cnt  out  CNT_W  number of terms accepted and matched; saturating.
- seq_ok  out  1  at least 2 terms matched and no error.
- err  out  1  sticky mismatch flag.
- err_idx  out  CNT_W  0-based index of first mismatching term.
- done  out  1  sequence exhausted, next term unrepresentable (non-wrap build only).

Behaviour:
- Reset (rst_n=0, async):
  - state=S_SEED0, prev_a=0, prev_b=0, exp_data=0, term_cnt=0, err=0, err_idx=0, done=0.
  - in_ready=0 while rst_n low.
- Transfer: occurs on a rising edge with in_valid=1 and in_ready=1. One term per cycle maximum, zero bubble.
- in_ready:
  - Combinational: 1 in S_SEED0, S_SEED1, S_RUN when clear=0.
  - 0 in S_ERR, S_DONE, or when clear=1.
- States:
  - S_SEED0: exp_data=0.
    - Match -> S_SEED1, prev_b=0, exp_data<=1.
    - Mismatch -> S_ERR.
  - S_SEED1: exp_data=1.
    - Match -> S_RUN, prev_a=0, prev_b=1, exp_data<=1.
    - Mismatch -> S_ERR.
  - S_RUN, on match:
    - prev_a<=prev_b, prev_b<=in_data.
    - exp_data<=prev_b+in_data, computed in WIDTH+1 bits.
  - S_RUN, on mismatch -> S_ERR.
  - S_ERR: terminal until clear; in_ready=0; outputs frozen.
  - S_DONE: terminal until clear (see Optional Feature).
- On every match: term_cnt<=term_cnt+1, saturating at 2^CNT_W-1 (no wrap).
- On mismatch:
  - err<=1, err_idx<=term_cnt (index of the offending term).
  - exp_data holds the expected value; term_cnt does not increment.
- seq_ok = (term_cnt>=2) && !err, registered-state derived, no input combinational path.
- clear=1 at an edge: same values as reset; any simultaneous in_valid is not accepted (in_ready=0).
- in_data is ignored when in_valid=0. A held in_valid with in_ready=0 is not an error.
- Latency: err/err_idx/term_cnt/exp_data update on the same edge that accepts the term (visible next cycle).

Optional Feature:
- Macro: FIB_CHK_WRAP_EN.
- Defined:
  - Expected sum is taken mod 2^WIDTH; checking continues indefinitely.
  - done is tied 0; S_DONE is unreachable.
- Undefined:
  - After a match in S_RUN, if prev_b+in_data overflows WIDTH bits, state<=S_DONE, done<=1, in_ready=0.
  - exp_data<=low WIDTH bits of the sum.
  - The overflowing sum is not treated as an error.

Test Plan:
- WIDTH=8, stream 0,1,1,2,3,5,8,13,21,34,55,89,144,233, in_valid held high:
  - 14 transfers in 14 consecutive cycles.
  - term_cnt=14, seq_ok=1, err=0.
  - Without FIB_CHK_WRAP_EN: done=1, in_ready=0.
  - With FIB_CHK_WRAP_EN: exp_data=121, in_ready=1.
- Stream 0,1,1,2,4:
  - err=1, err_idx=4, exp_data=3, term_cnt=4, seq_ok=0.
  - in_ready=0 and further terms are not accepted.
- First term 5 -> err=1, err_idx=0, exp_data=0, term_cnt=0.
- Stream 0,1,1 with in_valid toggling every other cycle, including cycles with in_data=8'hFF while in_valid=0 -> no error, term_cnt=3.
- Error state then clear=1 for one cycle with in_valid=1, in_data=0:
  - No transfer that cycle.
  - Next cycle: S_SEED0, err=0, term_cnt=0; following 0,1 accepted.
- rst_n asserted mid-stream (after term 6, asynchronously between edges) -> all outputs at reset values immediately; in_ready=0 until rst_n=1.
